// File: rtl/irq_ctl.sv
// Interrupt controller for a 65C02 core: synchronises N IRQ sources and one NMI,
// latches edge-mode requests, priority-encodes them and supplies a per-channel IRQ vector.
module irq_ctl #(
  parameter int          N_IRQ       = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] VEC_BASE    = 16'hFFE0
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             RDY,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             nmi_in,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [7:0]       reg_wdata,
  output logic [7:0]       reg_rdata,
  input  logic             irq_ack,
  input  logic             nmi_ack,
  output logic             IRQ,
  output logic             NMI,
  output logic [15:0]      vec_addr,
  output logic             vec_valid
);

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_MODE   = 2'd1;
  localparam logic [1:0] ADDR_PEND   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic [SYNC_STAGES-1:0][N_IRQ-1:0] irq_sync_q;
  logic [SYNC_STAGES-1:0]            nmi_sync_q;
  logic [N_IRQ-1:0] irq_prev_q;
  logic             nmi_prev_q;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] mode_q, mode_d;
  logic [N_IRQ-1:0] latch_q, latch_d;
  logic             nmi_pend_q, nmi_pend_d;
  logic             irq_q;
  logic [15:0]      vec_addr_q, vec_addr_d;
  logic             vec_valid_q, vec_valid_d;

  logic [N_IRQ-1:0] s_irq, irq_rise, pend, req, clr, win_oh;
  logic [2:0]       win;
  logic             req_any, s_nmi, nmi_rise;
  logic             ack_fire, nack_fire, wr_fire;
  logic             wdata_unused;

  // Handshake: irq_ack / nmi_ack and reg_we are single-cycle strobes that are
  // accepted only on a clock where RDY=1; with RDY=0 they are simply dropped.
  assign ack_fire  = irq_ack & RDY;
  assign nack_fire = nmi_ack & RDY;
  assign wr_fire   = reg_we & RDY;

  assign s_irq    = irq_sync_q[SYNC_STAGES-1];
  assign s_nmi    = nmi_sync_q[SYNC_STAGES-1];
  assign irq_rise = s_irq & ~irq_prev_q;
  assign nmi_rise = s_nmi & ~nmi_prev_q;

  assign pend    = (mode_q & latch_q) | (~mode_q & s_irq);
  assign req     = pend & mask_q;
  assign req_any = |req;

  always_comb begin
    win    = 3'd0;
    win_oh = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win       = 3'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    mask_d      = mask_q;
    mode_d      = mode_q;
    clr         = '0;
    vec_addr_d  = vec_addr_q;
    vec_valid_d = vec_valid_q;
    if (wr_fire && reg_addr == ADDR_MASK) mask_d = reg_wdata[N_IRQ-1:0];
    if (wr_fire && reg_addr == ADDR_MODE) mode_d = reg_wdata[N_IRQ-1:0];
    if (wr_fire && reg_addr == ADDR_PEND) clr = reg_wdata[N_IRQ-1:0];
    if (ack_fire) begin
      if (req_any) begin
        clr         = clr | win_oh;
        vec_addr_d  = VEC_BASE + {12'd0, win, 1'b0};
        vec_valid_d = 1'b1;
      end else begin
        vec_addr_d  = 16'hFFFE;
        vec_valid_d = 1'b0;
      end
    end
    // Gating with the next MODE clears a latch in the same clock its channel goes level.
    latch_d    = (irq_rise | (latch_q & ~clr)) & mode_d;
    nmi_pend_d = nmi_rise | (nmi_pend_q & ~nack_fire);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      irq_sync_q  <= '0;
      nmi_sync_q  <= '0;
      irq_prev_q  <= '0;
      nmi_prev_q  <= 1'b0;
      mask_q      <= '0;
      mode_q      <= '0;
      latch_q     <= '0;
      nmi_pend_q  <= 1'b0;
      irq_q       <= 1'b0;
      vec_addr_q  <= 16'hFFFE;
      vec_valid_q <= 1'b0;
    end else begin
      irq_sync_q  <= {irq_sync_q[SYNC_STAGES-2:0], irq_in};
      nmi_sync_q  <= {nmi_sync_q[SYNC_STAGES-2:0], nmi_in};
      irq_prev_q  <= s_irq;
      nmi_prev_q  <= s_nmi;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      latch_q     <= latch_d;
      nmi_pend_q  <= nmi_pend_d;
      irq_q       <= req_any;
      vec_addr_q  <= vec_addr_d;
      vec_valid_q <= vec_valid_d;
    end
  end

  always_comb begin
    reg_rdata = 8'h00;
    case (reg_addr)
      ADDR_MASK:   reg_rdata[N_IRQ-1:0] = mask_q;
      ADDR_MODE:   reg_rdata[N_IRQ-1:0] = mode_q;
      ADDR_PEND:   reg_rdata[N_IRQ-1:0] = pend;
      ADDR_STATUS: reg_rdata = {req_any, nmi_pend_q, vec_valid_q, 2'b00, win};
      default:     reg_rdata = 8'h00;
    endcase
  end

  // Write-data bits above the channel count have no home.
  assign wdata_unused = ^reg_wdata;

  assign IRQ       = irq_q;
  assign NMI       = nmi_pend_q;
  assign vec_addr  = vec_addr_q;
  assign vec_valid = vec_valid_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Bench for irq_ctl: directed scenarios plus random traffic, every cycle's outputs
// compared against a rule-level reference model through an expected-value queue.
`timescale 1ns/1ps
module tb_irq_ctl;
  localparam int          N  = 4;
  localparam int          S  = 2;
  localparam logic [15:0] VB = 16'hFFE0;
  localparam int          W  = 27;

  logic         clk = 1'b0;
  logic         RST = 1'b0;
  logic         RDY = 1'b1;
  logic [N-1:0] irq_in = '0;
  logic         nmi_in = 1'b0;
  logic         reg_we = 1'b0;
  logic [1:0]   reg_addr = 2'd0;
  logic [7:0]   reg_wdata = 8'h00;
  logic [7:0]   reg_rdata;
  logic         irq_ack = 1'b0;
  logic         nmi_ack = 1'b0;
  logic         IRQ, NMI, vec_valid;
  logic [15:0]  vec_addr;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  irq_ctl #(.N_IRQ(N), .SYNC_STAGES(S), .VEC_BASE(VB)) dut (
    .clk(clk), .RST(RST), .RDY(RDY), .irq_in(irq_in), .nmi_in(nmi_in),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .irq_ack(irq_ack), .nmi_ack(nmi_ack), .IRQ(IRQ), .NMI(NMI),
    .vec_addr(vec_addr), .vec_valid(vec_valid)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] m_mask, m_mode, m_latch, m_s, m_prev;
  logic         m_nmi_s, m_nmi_prev, m_nmi_pend, m_irq, m_valid;
  logic [15:0]  m_vec;
  logic [N-1:0] irq_line[$];
  logic         nmi_line[$];

  task automatic model_reset();
    m_mask = '0; m_mode = '0; m_latch = '0; m_s = '0; m_prev = '0;
    m_nmi_s = 0; m_nmi_prev = 0; m_nmi_pend = 0; m_irq = 0; m_valid = 0;
    m_vec = 16'hFFFE;
    irq_line.delete(); nmi_line.delete();
    for (int i = 0; i < S - 1; i++) begin
      irq_line.push_back('0);
      nmi_line.push_back(1'b0);
    end
  endtask

  function automatic logic [N-1:0] m_pend();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = m_mode[i] ? m_latch[i] : m_s[i];
    return p;
  endfunction

  function automatic int m_win(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a);
    logic [N-1:0] r;
    int w;
    logic [7:0] d;
    r = m_pend() & m_mask;
    w = m_win(r);
    d = 8'h00;
    case (a)
      2'd0: d[N-1:0] = m_mask;
      2'd1: d[N-1:0] = m_mode;
      2'd2: d[N-1:0] = m_pend();
      default: begin
        d[7] = (w >= 0);
        d[6] = m_nmi_pend;
        d[5] = m_valid;
        if (w >= 0) d[2:0] = 3'(w);
      end
    endcase
    return d;
  endfunction

  task automatic model_edge();
    logic [N-1:0] r, rise, clr, mode_n;
    int w;
    logic en, nrise;
    en = RDY;
    r = m_pend() & m_mask;
    w = m_win(r);
    rise = m_s & ~m_prev;
    clr = '0;
    mode_n = m_mode;
    if (en && reg_we && reg_addr == 2'd0) m_mask = reg_wdata[N-1:0];
    if (en && reg_we && reg_addr == 2'd1) mode_n = reg_wdata[N-1:0];
    if (en && reg_we && reg_addr == 2'd2) clr = reg_wdata[N-1:0];
    if (en && irq_ack && w >= 0) clr[w] = 1'b1;
    for (int i = 0; i < N; i++)
      m_latch[i] = mode_n[i] && (rise[i] || (m_latch[i] && !clr[i]));
    m_mode = mode_n;
    m_irq = (r != 0);
    if (en && irq_ack) begin
      if (w >= 0) begin m_vec = VB + 16'(2 * w); m_valid = 1'b1; end
      else begin m_vec = 16'hFFFE; m_valid = 1'b0; end
    end
    nrise = m_nmi_s && !m_nmi_prev;
    m_nmi_pend = nrise || (m_nmi_pend && !(en && nmi_ack));
    m_prev = m_s;
    irq_line.push_back(irq_in);
    m_s = irq_line.pop_front();
    m_nmi_prev = m_nmi_s;
    nmi_line.push_back(nmi_in);
    m_nmi_s = nmi_line.pop_front();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    exp_q.push_back({m_irq, m_nmi_pend, m_valid, m_vec, m_read(reg_addr)});
    @(negedge clk);
    #1;
    reg_we = 1'b0; irq_ack = 1'b0; nmi_ack = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
  endtask

  task automatic do_reset();
    #2;
    RST = 1'b1;
    reg_we = 1'b0; irq_ack = 1'b0; nmi_ack = 1'b0;
    #1;
    check("rst_irq", IRQ, 0);
    check("rst_nmi", NMI, 0);
    check("rst_vec_addr", vec_addr, 16'hFFFE);
    check("rst_vec_valid", vec_valid, 0);
    for (int a = 0; a < 4; a++) begin
      reg_addr = 2'(a);
      #1;
      check("rst_rdata", reg_rdata, 8'h00);
    end
    @(negedge clk);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [W-1:0] e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {IRQ, NMI, vec_valid, vec_addr, reg_rdata};
        check("outputs{irq,nmi,vv,vec,rd}", 32'(g), 32'(e));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int nmi_rises;
    logic nmi_last;
    model_reset();
    @(negedge clk);
    #1;
    do_reset();

    // Level-mode channel 2: latency, vector, release.
    wr(2'd0, 8'h0F);
    wr(2'd1, 8'h00);
    irq_in = 4'b0100;
    ticks(2);
    check("lvl_irq_before", IRQ, 0);
    tick();
    check("lvl_irq_after3", IRQ, 1);
    irq_ack = 1'b1; tick();
    check("lvl_vec", vec_addr, 16'hFFE4);
    check("lvl_valid", vec_valid, 1);
    irq_in = 4'b0000;
    ticks(2);
    check("lvl_irq_hold", IRQ, 1);
    tick();
    check("lvl_irq_drop", IRQ, 0);

    // Edge mode: two simultaneous pulses served in priority order.
    wr(2'd1, 8'h0F);
    irq_in = 4'b1010; tick();
    irq_in = 4'b0000; ticks(3);
    check("edge_irq", IRQ, 1);
    irq_ack = 1'b1; tick();
    check("edge_vec1", vec_addr, 16'hFFE2);
    tick();
    check("edge_irq_stays", IRQ, 1);
    irq_ack = 1'b1; tick();
    check("edge_vec2", vec_addr, 16'hFFE6);
    tick();
    check("edge_irq_drop", IRQ, 0);

    // Edge on ch2 coinciding with a PEND clear: set wins.
    irq_in = 4'b0100; ticks(2);
    wr(2'd2, 8'h04);
    check("pend_set_wins", reg_rdata, 8'h04);
    tick();
    check("pend_irq", IRQ, 1);
    wr(2'd2, 8'h04);
    tick();
    check("pend_clr_irq", IRQ, 0);
    irq_in = 4'b0000; ticks(3);

    // NMI: held high gives one request; ack; edge coincident with ack.
    nmi_in = 1'b1;
    nmi_rises = 0;
    nmi_last = NMI;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (NMI && !nmi_last) nmi_rises++;
      nmi_last = NMI;
    end
    check("nmi_one_request", nmi_rises, 1);
    nmi_ack = 1'b1; tick();
    check("nmi_ack_clear", NMI, 0);
    ticks(3);
    check("nmi_held_no_retrigger", NMI, 0);
    nmi_in = 1'b0; ticks(3);
    nmi_in = 1'b1; ticks(3);
    check("nmi_pulse1", NMI, 1);
    nmi_in = 1'b0; ticks(3);
    nmi_in = 1'b1; ticks(2);
    nmi_ack = 1'b1; tick();
    check("nmi_edge_wins", NMI, 1);
    nmi_ack = 1'b1; tick();
    check("nmi_ack2", NMI, 0);
    nmi_in = 1'b0; ticks(3);

    // RDY=0 blocks acks and writes; masked request gives spurious vector.
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h0F);
    irq_in = 4'b0001; ticks(3);
    check("rdy_irq", IRQ, 1);
    RDY = 1'b0; reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = 8'h00; irq_ack = 1'b1;
    tick();
    RDY = 1'b1;
    check("rdy0_vec_hold", vec_addr, 16'hFFE6);
    reg_addr = 2'd0;
    #1;
    check("rdy0_mask_hold", reg_rdata, 8'h0F);
    wr(2'd0, 8'h00);
    tick();
    check("masked_irq", IRQ, 0);
    irq_ack = 1'b1; tick();
    check("spurious_vec", vec_addr, 16'hFFFE);
    check("spurious_valid", vec_valid, 0);
    irq_in = 4'b0000; ticks(3);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) irq_in[i] = ~irq_in[i];
      if ($urandom_range(9) == 0) nmi_in = ~nmi_in;
      RDY = ($urandom_range(4) != 0);
      reg_addr = 2'($urandom_range(3));
      if ($urandom_range(5) == 0) begin
        reg_we = 1'b1;
        reg_wdata = 8'($urandom_range(255));
      end
      irq_ack = ($urandom_range(3) == 0);
      nmi_ack = ($urandom_range(4) == 0);
      tick();
      if (c == 1000) do_reset();
    end
    RDY = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
